// File: rtl/stream_rx_fifo.sv
// Checked tail-of-chain consumer: buffers upstream valid/ready words in a small
// FIFO, pops them under a local read enable and checks for an incrementing sequence.
module stream_rx_fifo #(
  parameter int L     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [L-1:0] data_in,
  output logic         ready,
  input  logic         ren,
  output logic [L-1:0] data_out,
  output logic         out_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic         err,
  output logic [7:0]   err_cnt,
  output logic         o_seq_track
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Handshake: a word transfers on a rising edge when valid && ready; ready is
  // derived from registered occupancy only, never from valid.
  typedef enum logic {SEQ_IDLE = 1'b0, SEQ_TRACK = 1'b1} seq_state_t;

  logic [L-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [L-1:0]  r_data_out;
  logic          r_out_valid;
  seq_state_t    r_seq_state;
  logic [L-1:0]  r_exp;
  logic          r_err;
  logic [7:0]    r_err_cnt;

  logic          w_ready;
  logic          w_push;
  logic          w_pop;
  seq_state_t    w_seq_next;
  logic [L-1:0]  w_exp_next;
  logic          w_err_next;
  logic [7:0]    w_err_cnt_next;

  assign w_ready = rst && (r_count != FULL_CNT);
  assign w_push  = valid && w_ready;
  assign w_pop   = ren && (r_count != '0);

  // Storage is not reset; w_push is already blocked while rst is low.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_data_out  <= r_mem[r_rd_ptr];
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + AW'(1);
      end else begin
        r_out_valid <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_seq_state <= SEQ_IDLE;
      r_exp       <= '0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_seq_state <= w_seq_next;
      r_exp       <= w_exp_next;
      r_err       <= w_err_next;
      r_err_cnt   <= w_err_cnt_next;
    end
  end

  // Every accepted word reloads the expectation, so a mismatch resynchronises.
  always_comb begin
    w_seq_next     = r_seq_state;
    w_exp_next     = r_exp;
    w_err_next     = r_err;
    w_err_cnt_next = r_err_cnt;
    if (w_push) begin
      w_exp_next = data_in + L'(1);
      w_seq_next = SEQ_TRACK;
      if (r_seq_state == SEQ_TRACK && data_in != r_exp) begin
        w_err_next     = 1'b1;
        w_err_cnt_next = (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
      end
    end
  end

  assign ready       = w_ready;
  assign data_out    = r_data_out;
  assign out_valid   = r_out_valid;
  assign count       = r_count;
  assign err         = r_err;
  assign err_cnt     = r_err_cnt;
  assign o_seq_track = (r_seq_state == SEQ_TRACK);
endmodule

// File: doc/stream_rx_fifo.md
# stream_rx_fifo

Receiving-end endpoint for the valid/ready stream produced by the master and its forward and backward pipe stages. It accepts words on the upstream handshake into a small FIFO and releases them to local logic under a read enable. It also runs an incrementing-sequence checker on accepted words, with a sticky error flag and an error counter. It sits at the tail of the handcont chain, in place of a plain slave, as the checked consumer of the stream.

## Interface

Parameters:
- L, 8, data width in bits
- DEPTH, 4, FIFO entries; power of two, ≥2
- AW, $clog2(DEPTH), derived localparam, pointer width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-low
- valid  in  1  upstream word valid
- data_in  in  L  upstream word
- ready  out  1  FIFO can accept a word
- ren  in  1  local read request
- data_out  out  L  popped word, registered
- out_valid  out  1  one-cycle pulse: data_out updated this cycle
- count  out  AW+1  current FIFO occupancy, 0..DEPTH
- err  out  1  sticky sequence-error flag
- err_cnt  out  8  number of sequence mismatches, saturating at 255

## Operation

- Push: a word is accepted on a rising edge when `valid && ready`. It is written to `mem[wr_ptr]` and `wr_ptr` increments modulo DEPTH.
- `ready = rst && (count != DEPTH)`.
  - Combinational from registered state only; it never depends on `valid`.
  - `ready` is 0 while `rst` is low.
- Pop: occurs on a rising edge when `ren && count != 0`.
  - `data_out <= mem[rd_ptr]` and `out_valid <= 1`.
  - `rd_ptr` increments modulo DEPTH.
  - Otherwise `out_valid <= 0` and `data_out` holds its value.
- `ren` while empty is ignored: no pop, no error, and pointers are unchanged.
- `count` update per edge:
  - +1 on push only
  - −1 on pop only
  - unchanged on push and pop together, or on neither
- Full with `ren`: the pop happens. `ready` was 0 that cycle, so no push occurs; `ready` returns to 1 on the next cycle.
- Empty with `valid`: the push happens and the pop does not. The word can be popped no earlier than the next edge; there is no bypass path.
- Upstream holding `valid` with stable data while `ready` is 0 must not produce a duplicate push or a lost word.
- Sequence checker, two-state FSM, evaluated only on accepted pushes:
  - SEQ_IDLE (reset state): first push → `exp <= data_in + 1` (mod 2^L); go to SEQ_TRACK.
  - SEQ_TRACK, push with `data_in == exp`: `exp <= data_in + 1`.
  - SEQ_TRACK, push with `data_in != exp`:
    - `err <= 1`
    - `err_cnt <= min(err_cnt + 1, 255)`
    - `exp <= data_in + 1` (resynchronise)
    - Stay in SEQ_TRACK.
  - Wrap-around: `exp` after `2^L − 1` is 0, and 0 following `2^L − 1` is not an error.
- `err` and `err_cnt` are cleared only by reset.

## Timing

- Reset (rst low at an edge):
  - pointers = 0, `count` = 0
  - `data_out` = 0, `out_valid` = 0
  - `err` = 0, `err_cnt` = 0
  - FSM = SEQ_IDLE
  - FIFO contents are discarded; memory need not be cleared.
- Reset mid-operation: all buffered words are lost, and no pop or push takes effect on the reset edge. The first cycle after release has `ready` = 1 and `count` = 0.
- Latency, push to pop: a word pushed at edge N is eligible at edge N+1. With `ren` high at N+1, `data_out` and `out_valid` are visible after edge N+1.
- Throughput: one push and one pop per cycle sustained. With `ren` held high, `count` stays ≤1 and `ready` never drops.
- Error timing: `err` and `err_cnt` update on the same edge as the offending push.

## Test plan

- **Reset:** hold rst = 0 for 3 cycles with valid = 1 → ready = 0, count = 0, out_valid = 0, err = 0 throughout. After release, ready = 1 and count = 0.
- **Fill, drain, order, full/empty:**
  - Stimulus: ren = 0, push 0x10..0x13 (DEPTH = 4), keep valid = 1 offering 0x14.
  - While full: count = 4, ready = 0, and 0x14 is held, not accepted.
  - Then ren = 1 → data_out = 0x10, 0x11, 0x12, 0x13, 0x14 on successive pulses, err = 0.
  - ren continued on empty → no out_valid and no change.
- **Streaming:** valid = 1 and ren = 1 continuously with data 0xFD, 0xFE, 0xFF, 0x00, 0x01 → each word appears one cycle after acceptance, ready stays 1, and err = 0 across the wrap.
- **Sequence error:**
  - Stimulus: push 0x05, 0x06, 0x09, 0x0A.
  - err rises on the 0x09 push edge, err_cnt = 1.
  - 0x0A is not an error (resync).
  - err stays 1 after further correct words.
- **Saturation:** push 300 words alternating 0x00/0x80 with ren = 1 → err_cnt stops at 255, and no wrap to 0.
- **Reset mid-operation:** with count = 3 and err = 1, pulse rst low for 1 cycle → count = 0, err = 0, err_cnt = 0, FSM in SEQ_IDLE. The next push of any value (e.g. 0x42) raises no error.
